// File: rtl/sflash_pkg.sv
// ----------------------------------------------------------------------------
// sflash_pkg
// Shared definitions for the SPI flash responder: the opcodes it understands,
// the one-hot state encoding, the data-lane width codes, where DOUT bytes come
// from, and what happens to the write-enable latch when CS# rises.
// No ports (package).
// ----------------------------------------------------------------------------
package sflash_pkg;

    localparam logic [7:0] OP_RD   = 8'h03;
    localparam logic [7:0] OP_FRD  = 8'h0B;
    localparam logic [7:0] OP_DOR  = 8'h3B;
    localparam logic [7:0] OP_QOR  = 8'h6B;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_PP   = 8'h02;

    typedef enum logic [6:0] {
        ST_IDLE   = 7'b0000001,
        ST_CMD    = 7'b0000010,
        ST_ADDR   = 7'b0000100,
        ST_DUMMY  = 7'b0001000,
        ST_DOUT   = 7'b0010000,
        ST_DIN    = 7'b0100000,
        ST_IGNORE = 7'b1000000
    } state_t;

    typedef enum logic [1:0] {
        LANE_SINGLE = 2'd0,
        LANE_DUAL   = 2'd1,
        LANE_QUAD   = 2'd2
    } lane_t;

    typedef enum logic [1:0] {
        SRC_MEM    = 2'd0,
        SRC_JEDEC  = 2'd1,
        SRC_STATUS = 2'd2
    } src_t;

    typedef enum logic [1:0] {
        WEL_KEEP  = 2'd0,
        WEL_SET   = 2'd1,
        WEL_CLEAR = 2'd2
    } welAct_t;

    // Output enables for the pins a given lane width drives.
    function automatic logic [3:0] laneOe(lane_t lane);
        case (lane)
            LANE_DUAL: return 4'b0011;
            LANE_QUAD: return 4'b1111;
            default:   return 4'b0010;
        endcase
    endfunction

    // Index of the last SCLK rise of a byte for a given lane width.
    function automatic logic [4:0] laneLastRise(lane_t lane);
        case (lane)
            LANE_DUAL: return 5'd3;
            LANE_QUAD: return 5'd1;
            default:   return 5'd7;
        endcase
    endfunction

endpackage

// File: rtl/sflash_responder_pin_sync.sv
// ----------------------------------------------------------------------------
// spi_pin_sync
// Brings the asynchronous SPI pins into the clk domain and turns SCLK / CS#
// transitions into single-clk pulses.
// Ports:
//   clk, arstn       module clock, asynchronous active-low reset
//   i_sclk, i_csN    raw SPI clock and chip select
//   i_io             raw IO pins from the master
//   o_sclkRise/Fall  one-clk pulses on synchronized SCLK edges
//   o_csRise/Fall    one-clk pulses on synchronized CS# edges
//   o_csN, o_io      synchronized CS# and IO pins
// ----------------------------------------------------------------------------
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       i_sclk,
    input  logic       i_csN,
    input  logic [3:0] i_io,
    output logic       o_sclkRise,
    output logic       o_sclkFall,
    output logic       o_csRise,
    output logic       o_csFall,
    output logic       o_csN,
    output logic [3:0] o_io
);

    logic [SYNC_STAGES-1:0]      r_sclkSync;
    logic [SYNC_STAGES-1:0]      r_csSync;
    logic [SYNC_STAGES-1:0][3:0] r_ioSync;
    logic                        r_sclkPrev;
    logic                        r_csPrev;

    // Synchronizer chains plus one history flop for edge detection. SCLK and
    // CS# reset to their idle-high levels so no edge is seen out of reset.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_sclkSync <= '1;
            r_csSync   <= '1;
            r_ioSync   <= '0;
            r_sclkPrev <= 1'b1;
            r_csPrev   <= 1'b1;
        end else begin
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], i_sclk};
            r_csSync   <= {r_csSync[SYNC_STAGES-2:0], i_csN};
            r_ioSync   <= {r_ioSync[SYNC_STAGES-2:0], i_io};
            r_sclkPrev <= r_sclkSync[SYNC_STAGES-1];
            r_csPrev   <= r_csSync[SYNC_STAGES-1];
        end
    end

    assign o_sclkRise = r_sclkSync[SYNC_STAGES-1] & ~r_sclkPrev;
    assign o_sclkFall = ~r_sclkSync[SYNC_STAGES-1] & r_sclkPrev;
    assign o_csRise   = r_csSync[SYNC_STAGES-1] & ~r_csPrev;
    assign o_csFall   = ~r_csSync[SYNC_STAGES-1] & r_csPrev;
    assign o_csN      = r_csSync[SYNC_STAGES-1];
    assign o_io       = r_ioSync[SYNC_STAGES-1];

endmodule

// File: rtl/sflash_responder.sv
// ----------------------------------------------------------------------------
// sflash_responder
// Target side of an SPI flash link (mode 3). Decodes the master's commands on
// oversampled pins and serves a byte-wide memory port: single/dual/quad reads,
// status, JEDEC ID, WREN/WRDI and page program.
// Ports:
//   clk, arstn            module clock, asynchronous active-low reset
//   i_spi_sclk/cs_n       SPI clock and chip select from the master
//   i_io_in               IO pins from the master (bit 0 = SI)
//   o_io_out, o_io_oe     IO pins to the master and their enables (bit 1 = SO)
//   o_mem_addr            byte address for both reads and writes
//   o_mem_rd, i_mem_rdata read strobe; data is expected one clk later
//   o_mem_wr, o_mem_wdata one-clk write strobe and data
//   o_busy                synchronized CS# active
// ----------------------------------------------------------------------------
module sflash_responder #(
    parameter logic [23:0] JEDEC_ID    = 24'hC84015,
    parameter int          DUMMY_CLKS  = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        i_spi_sclk,
    input  logic        i_spi_cs_n,
    input  logic [3:0]  i_io_in,
    output logic [3:0]  o_io_out,
    output logic [3:0]  o_io_oe,
    output logic [23:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_mem_wr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_busy
);
    import sflash_pkg::*;

    logic       w_sclkRise, w_sclkFall, w_csRise, w_csFall, w_csN;
    logic [3:0] w_io;
    logic       w_rise, w_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .arstn      (arstn),
        .i_sclk     (i_spi_sclk),
        .i_csN      (i_spi_cs_n),
        .i_io       (i_io_in),
        .o_sclkRise (w_sclkRise),
        .o_sclkFall (w_sclkFall),
        .o_csRise   (w_csRise),
        .o_csFall   (w_csFall),
        .o_csN      (w_csN),
        .o_io       (w_io)
    );

    // SCLK edges only count while the part is selected.
    assign w_rise = w_sclkRise & ~w_csN;
    assign w_fall = w_sclkFall & ~w_csN;

    state_t      r_state, w_nextState, w_decState;
    lane_t       r_lane, w_laneNext, w_decLane;
    src_t        r_src, w_decSrc;
    welAct_t     r_welAct, w_decWelAct;
    logic [4:0]  r_bitCnt;
    logic [6:0]  r_cmd, r_dinShift;
    logic [23:0] r_addr, r_memAddr;
    logic [7:0]  r_shiftOut, r_buf, r_memWdata;
    logic [3:0]  r_ioOut, r_ioOe, w_oeNext;
    logic [1:0]  r_idCnt;
    logic        r_needDummy, r_isWrite, r_wel, r_memRd, r_memWr, r_rdLoad, r_firstLoad;
    logic        w_decDummy, w_decWrite, w_cmdDone;
    logic [7:0]  w_cmdByte;
    logic [23:0] w_addrFull;

    assign w_cmdByte  = {r_cmd, w_io[0]};
    assign w_addrFull = {r_addr[22:0], w_io[0]};
    assign w_cmdDone  = (r_state == ST_CMD) && w_rise && (r_bitCnt == 5'd7);

    // State register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    // Opcode decode, next-state selection and the enables for the next cycle.
    // A program opcode with WEL clear is parked in IGNORE so it never writes.
    always_comb begin
        w_decState  = ST_IGNORE;
        w_decLane   = LANE_SINGLE;
        w_decSrc    = SRC_MEM;
        w_decDummy  = 1'b0;
        w_decWrite  = 1'b0;
        w_decWelAct = WEL_KEEP;
        case (w_cmdByte)
            OP_RD:   w_decState = ST_ADDR;
            OP_FRD:  begin w_decState = ST_ADDR; w_decDummy = (DUMMY_CLKS != 0); end
            OP_DOR:  begin w_decState = ST_ADDR; w_decDummy = (DUMMY_CLKS != 0); w_decLane = LANE_DUAL; end
            OP_QOR:  begin w_decState = ST_ADDR; w_decDummy = (DUMMY_CLKS != 0); w_decLane = LANE_QUAD; end
            OP_RDID: begin w_decState = ST_DOUT; w_decSrc = SRC_JEDEC; end
            OP_RDSR: begin w_decState = ST_DOUT; w_decSrc = SRC_STATUS; end
            OP_WREN: w_decWelAct = WEL_SET;
            OP_WRDI: w_decWelAct = WEL_CLEAR;
            OP_PP:   begin
                w_decWelAct = WEL_CLEAR;
                w_decWrite  = 1'b1;
                if (r_wel) w_decState = ST_ADDR;
            end
            default: ;
        endcase

        w_nextState = r_state;
        if (w_csRise) begin
            w_nextState = ST_IDLE;
        end else if (w_csFall) begin
            w_nextState = ST_CMD;
        end else if (w_rise) begin
            case (r_state)
                ST_CMD:   if (r_bitCnt == 5'd7) w_nextState = w_decState;
                ST_ADDR:  if (r_bitCnt == 5'd23)
                              w_nextState = r_isWrite ? ST_DIN : (r_needDummy ? ST_DUMMY : ST_DOUT);
                ST_DUMMY: if (r_bitCnt == 5'(DUMMY_CLKS - 1)) w_nextState = ST_DOUT;
                default:  ;
            endcase
        end

        w_laneNext = w_cmdDone ? w_decLane : r_lane;
        w_oeNext   = (w_nextState == ST_DOUT) ? laneOe(w_laneNext) : 4'b0000;
    end

    // Datapath. The read pipeline keeps one byte ahead in r_buf: the first
    // returned byte goes straight into the shifter and immediately triggers a
    // prefetch of the next address, and every byte boundary swaps r_buf in and
    // prefetches again. r_addr always holds the next address to access.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_lane      <= LANE_SINGLE;
            r_src       <= SRC_MEM;
            r_welAct    <= WEL_KEEP;
            r_bitCnt    <= '0;
            r_cmd       <= '0;
            r_dinShift  <= '0;
            r_addr      <= '0;
            r_memAddr   <= '0;
            r_shiftOut  <= '0;
            r_buf       <= '0;
            r_memWdata  <= '0;
            r_ioOut     <= '0;
            r_ioOe      <= '0;
            r_idCnt     <= '0;
            r_needDummy <= 1'b0;
            r_isWrite   <= 1'b0;
            r_wel       <= 1'b0;
            r_memRd     <= 1'b0;
            r_memWr     <= 1'b0;
            r_rdLoad    <= 1'b0;
            r_firstLoad <= 1'b0;
        end else begin
            r_memRd  <= 1'b0;
            r_memWr  <= 1'b0;
            r_rdLoad <= r_memRd;
            r_lane   <= w_laneNext;
            r_ioOe   <= w_oeNext;
            if (w_csRise) begin
                r_bitCnt    <= '0;
                r_ioOut     <= '0;
                r_firstLoad <= 1'b0;
                r_welAct    <= WEL_KEEP;
                if (r_welAct == WEL_SET)   r_wel <= 1'b1;
                if (r_welAct == WEL_CLEAR) r_wel <= 1'b0;
            end else if (w_csFall) begin
                r_bitCnt <= '0;
                r_welAct <= WEL_KEEP;
            end else begin
                if (r_rdLoad && r_state == ST_DOUT) begin
                    if (r_firstLoad) begin
                        r_shiftOut  <= i_mem_rdata;
                        r_firstLoad <= 1'b0;
                        r_memRd     <= 1'b1;
                        r_memAddr   <= r_addr;
                        r_addr      <= r_addr + 24'd1;
                    end else begin
                        r_buf <= i_mem_rdata;
                    end
                end
                if (w_fall && r_state == ST_DOUT) begin
                    case (r_lane)
                        LANE_DUAL: begin
                            r_ioOut    <= {2'b00, r_shiftOut[7:6]};
                            r_shiftOut <= {r_shiftOut[5:0], 2'b00};
                        end
                        LANE_QUAD: begin
                            r_ioOut    <= r_shiftOut[7:4];
                            r_shiftOut <= {r_shiftOut[3:0], 4'b0000};
                        end
                        default: begin
                            r_ioOut    <= {2'b00, r_shiftOut[7], 1'b0};
                            r_shiftOut <= {r_shiftOut[6:0], 1'b0};
                        end
                    endcase
                end
                if (w_rise) begin
                    r_bitCnt <= r_bitCnt + 5'd1;
                    case (r_state)
                        ST_CMD: begin
                            r_cmd <= w_cmdByte[6:0];
                            if (r_bitCnt == 5'd7) begin
                                r_bitCnt    <= '0;
                                r_src       <= w_decSrc;
                                r_needDummy <= w_decDummy;
                                r_isWrite   <= w_decWrite;
                                r_welAct    <= w_decWelAct;
                                r_idCnt     <= 2'd1;
                                if (w_decSrc == SRC_JEDEC)  r_shiftOut <= JEDEC_ID[23:16];
                                if (w_decSrc == SRC_STATUS) r_shiftOut <= {6'b0, r_wel, 1'b0};
                            end
                        end
                        ST_ADDR: begin
                            r_addr <= w_addrFull;
                            if (r_bitCnt == 5'd23) begin
                                r_bitCnt <= '0;
                                if (!r_isWrite && !r_needDummy) begin
                                    r_memRd     <= 1'b1;
                                    r_memAddr   <= w_addrFull;
                                    r_addr      <= w_addrFull + 24'd1;
                                    r_firstLoad <= 1'b1;
                                end
                            end
                        end
                        ST_DUMMY: begin
                            if (r_bitCnt == 5'(DUMMY_CLKS - 1)) begin
                                r_bitCnt    <= '0;
                                r_memRd     <= 1'b1;
                                r_memAddr   <= r_addr;
                                r_addr      <= r_addr + 24'd1;
                                r_firstLoad <= 1'b1;
                            end
                        end
                        ST_DIN: begin
                            r_dinShift <= {r_dinShift[5:0], w_io[0]};
                            if (r_bitCnt == 5'd7) begin
                                r_bitCnt   <= '0;
                                r_memWr    <= 1'b1;
                                r_memWdata <= {r_dinShift, w_io[0]};
                                r_memAddr  <= r_addr;
                                r_addr     <= r_addr + 24'd1;
                            end
                        end
                        ST_DOUT: begin
                            if (r_bitCnt == laneLastRise(r_lane)) begin
                                r_bitCnt <= '0;
                                case (r_src)
                                    SRC_JEDEC: begin
                                        if (r_idCnt == 2'd1)      r_shiftOut <= JEDEC_ID[15:8];
                                        else if (r_idCnt == 2'd2) r_shiftOut <= JEDEC_ID[7:0];
                                        else                      r_shiftOut <= 8'h00;
                                        if (r_idCnt != 2'd3) r_idCnt <= r_idCnt + 2'd1;
                                    end
                                    SRC_STATUS: r_shiftOut <= {6'b0, r_wel, 1'b0};
                                    default: begin
                                        r_shiftOut <= r_buf;
                                        r_memRd    <= 1'b1;
                                        r_memAddr  <= r_addr;
                                        r_addr     <= r_addr + 24'd1;
                                    end
                                endcase
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign o_io_out    = r_ioOut;
    assign o_io_oe     = r_ioOe;
    assign o_mem_addr  = r_memAddr;
    assign o_mem_rd    = r_memRd;
    assign o_mem_wr    = r_memWr;
    assign o_mem_wdata = r_memWdata;
    assign o_busy      = ~w_csN;

endmodule

// File: tb/tb_sflash_responder.sv
// ----------------------------------------------------------------------------
// tb_sflash_responder
// Drives sflash_responder as a mode-3 SPI master (SCLK half-period of 8 clk)
// against a sparse byte memory. Expected read addresses, write strobes and
// received bytes are queued by the stimulus and compared by monitors.
// ----------------------------------------------------------------------------
module tb_sflash_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        arstn;
    logic        sclk, cs_n;
    logic [3:0]  io_in;
    logic [3:0]  io_out, io_oe;
    logic [23:0] mem_addr;
    logic        mem_rd, mem_wr, busy;
    logic [7:0]  mem_rdata, mem_wdata;

    logic [7:0]  mem [int];
    logic [23:0] expRdQ[$];
    logic [31:0] expWrQ[$];
    logic [7:0]  expRxQ[$];
    logic [7:0]  obsRxQ[$];
    int          nChecks = 0;
    int          nErrors = 0;
    int          wrCount = 0;
    int          wrBefore;

    sflash_responder dut (
        .clk         (clk),
        .arstn       (arstn),
        .i_spi_sclk  (sclk),
        .i_spi_cs_n  (cs_n),
        .i_io_in     (io_in),
        .o_io_out    (io_out),
        .o_io_oe     (io_oe),
        .o_mem_addr  (mem_addr),
        .o_mem_rd    (mem_rd),
        .i_mem_rdata (mem_rdata),
        .o_mem_wr    (mem_wr),
        .o_mem_wdata (mem_wdata),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory model: registered read data one clk after the strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
        if (mem_wr) mem[int'(mem_addr)] = mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Monitors: memory strobes and bytes the master has received.
    always @(negedge clk) begin
        if (mem_rd && mem_wr) checkOutput("rd_wr_exclusive", 32'd1, 32'd0);
        if (mem_rd && expRdQ.size() > 0) checkOutput("mem_rd_addr", {8'h00, mem_addr}, {8'h00, expRdQ.pop_front()});
        if (mem_wr) begin
            wrCount++;
            if (expWrQ.size() > 0) begin
                checkOutput("mem_wr_addr_data", {mem_addr, mem_wdata}, expWrQ.pop_front());
            end else begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL mem_wr_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end
        end
        if (obsRxQ.size() > 0) begin
            if (expRxQ.size() > 0) begin
                checkOutput("rx_byte", {24'h0, obsRxQ.pop_front()}, {24'h0, expRxQ.pop_front()});
            end else begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL rx_unexpected: got %h, required nothing", obsRxQ.pop_front());
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csLow();
        cs_n = 1'b0;
        waitClk(HALF);
        checkOutput("busy_selected", {31'd0, busy}, 32'd1);
        checkOutput("oe_before_cmd", {28'd0, io_oe}, 32'd0);
    endtask

    task automatic csHigh();
        waitClk(HALF);
        cs_n = 1'b1;
        waitClk(2 * HALF);
        checkOutput("busy_released", {31'd0, busy}, 32'd0);
        checkOutput("oe_after_cs", {28'd0, io_oe}, 32'd0);
    endtask

    task automatic sclkPulse(input logic bitIn);
        sclk  = 1'b0;
        io_in = {3'b000, bitIn};
        waitClk(HALF);
        sclk = 1'b1;
        waitClk(HALF);
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sclkPulse(b[i]);
    endtask

    task automatic recvByte(input int lanes, input logic [3:0] expOe);
        logic [7:0] b = 8'h00;
        for (int k = 0; k < 8 / lanes; k++) begin
            sclk = 1'b0;
            waitClk(HALF);
            if (k == 0) checkOutput("oe_data", {28'd0, io_oe}, {28'd0, expOe});
            if (lanes == 4)      b = {b[3:0], io_out};
            else if (lanes == 2) b = {b[5:0], io_out[1:0]};
            else                 b = {b[6:0], io_out[1]};
            sclk = 1'b1;
            waitClk(HALF);
        end
        obsRxQ.push_back(b);
    endtask

    // One complete CS# frame: opcode, optional address, dummy clocks,
    // up to four written bytes (MSB of txData first) and nRx read bytes.
    task automatic applyStimulus(input logic [7:0] op, input bit hasAddr, input logic [23:0] addr,
                                 input int dummyN, input int lanes, input logic [3:0] expOe,
                                 input int nRx, input int nTx, input logic [31:0] txData);
        logic [31:0] tx = txData;
        csLow();
        sendByte(op);
        if (hasAddr) begin
            sendByte(addr[23:16]);
            sendByte(addr[15:8]);
            sendByte(addr[7:0]);
        end
        for (int i = 0; i < dummyN; i++) sclkPulse(1'b0);
        for (int i = 0; i < nTx; i++) begin
            sendByte(tx[31:24]);
            tx = tx << 8;
        end
        for (int i = 0; i < nRx; i++) recvByte(lanes, expOe);
        csHigh();
    endtask

    task automatic drainCheck();
        waitClk(4);
        checkOutput("rd_queue_drained", expRdQ.size(), 32'd0);
        checkOutput("wr_queue_drained", expWrQ.size(), 32'd0);
        checkOutput("rx_queue_drained", expRxQ.size(), 32'd0);
    endtask

    initial begin
        sclk  = 1'b1;
        cs_n  = 1'b1;
        io_in = 4'h0;
        arstn = 1'b0;
        mem[32'h0000FF] = 8'hA5;
        mem[32'h000100] = 8'h3C;
        mem[32'h000010] = 8'h12;
        mem[32'h000011] = 8'h34;
        mem[32'hFFFFFF] = 8'h5A;
        mem[32'h000000] = 8'hC3;
        waitClk(5);
        checkOutput("rst_io_oe",   {28'd0, io_oe}, 32'd0);
        checkOutput("rst_io_out",  {28'd0, io_out}, 32'd0);
        checkOutput("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
        checkOutput("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        checkOutput("rst_busy",    {31'd0, busy}, 32'd0);
        arstn = 1'b1;
        waitClk(5);

        // JEDEC ID then zero fill.
        expRxQ.push_back(8'hC8); expRxQ.push_back(8'h40);
        expRxQ.push_back(8'h15); expRxQ.push_back(8'h00);
        applyStimulus(8'h9F, 1'b0, 24'h0, 0, 1, 4'b0010, 4, 0, 32'h0);
        drainCheck();

        // Single read crossing 0xFF -> 0x100.
        expRdQ.push_back(24'h0000FF); expRdQ.push_back(24'h000100);
        expRxQ.push_back(8'hA5); expRxQ.push_back(8'h3C);
        applyStimulus(8'h03, 1'b1, 24'h0000FF, 0, 1, 4'b0010, 2, 0, 32'h0);
        drainCheck();

        // Quad output read with 8 dummy clocks.
        expRdQ.push_back(24'h000010); expRdQ.push_back(24'h000011);
        expRxQ.push_back(8'h12); expRxQ.push_back(8'h34);
        applyStimulus(8'h6B, 1'b1, 24'h000010, 8, 4, 4'b1111, 2, 0, 32'h0);
        drainCheck();

        // Program without WEL must not write.
        wrBefore = wrCount;
        applyStimulus(8'h02, 1'b1, 24'h000020, 0, 1, 4'b0010, 0, 1, 32'h55000000);
        checkOutput("pp_without_wel", wrCount - wrBefore, 32'd0);

        // WREN, status shows WEL, program two bytes, status clears, read back.
        applyStimulus(8'h06, 1'b0, 24'h0, 0, 1, 4'b0010, 0, 0, 32'h0);
        expRxQ.push_back(8'h02);
        applyStimulus(8'h05, 1'b0, 24'h0, 0, 1, 4'b0010, 1, 0, 32'h0);
        expWrQ.push_back({24'h000020, 8'h55}); expWrQ.push_back({24'h000021, 8'hAA});
        applyStimulus(8'h02, 1'b1, 24'h000020, 0, 1, 4'b0010, 0, 2, 32'h55AA0000);
        expRxQ.push_back(8'h00);
        applyStimulus(8'h05, 1'b0, 24'h0, 0, 1, 4'b0010, 1, 0, 32'h0);
        expRdQ.push_back(24'h000020); expRdQ.push_back(24'h000021);
        expRxQ.push_back(8'h55); expRxQ.push_back(8'hAA);
        applyStimulus(8'h03, 1'b1, 24'h000020, 0, 1, 4'b0010, 2, 0, 32'h0);
        drainCheck();

        // Program aborted after 5 data bits: no write, back to IDLE.
        applyStimulus(8'h06, 1'b0, 24'h0, 0, 1, 4'b0010, 0, 0, 32'h0);
        wrBefore = wrCount;
        csLow();
        sendByte(8'h02);
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h40);
        for (int i = 0; i < 5; i++) sclkPulse(i[0]);
        csHigh();
        checkOutput("partial_byte_no_write", wrCount - wrBefore, 32'd0);
        expRxQ.push_back(8'hC8);
        applyStimulus(8'h9F, 1'b0, 24'h0, 0, 1, 4'b0010, 1, 0, 32'h0);
        expRxQ.push_back(8'h00);
        applyStimulus(8'h05, 1'b0, 24'h0, 0, 1, 4'b0010, 1, 0, 32'h0);
        drainCheck();

        // Address wrap at the top of the 24-bit space.
        expRdQ.push_back(24'hFFFFFF); expRdQ.push_back(24'h000000);
        expRxQ.push_back(8'h5A); expRxQ.push_back(8'hC3);
        applyStimulus(8'h03, 1'b1, 24'hFFFFFF, 0, 1, 4'b0010, 2, 0, 32'h0);
        drainCheck();

        // Reset in the middle of a data phase.
        csLow();
        sendByte(8'h03);
        sendByte(8'h00); sendByte(8'h03); sendByte(8'h00);
        sclk = 1'b0;
        waitClk(HALF);
        checkOutput("oe_before_reset", {28'd0, io_oe}, 32'h2);
        sclk = 1'b1;
        waitClk(HALF);
        sclk = 1'b0;
        waitClk(HALF / 2);
        arstn = 1'b0;
        #1;
        checkOutput("reset_io_oe",   {28'd0, io_oe}, 32'd0);
        checkOutput("reset_mem_addr", {8'd0, mem_addr}, 32'd0);
        checkOutput("reset_busy",    {31'd0, busy}, 32'd0);
        sclk = 1'b1;
        cs_n = 1'b1;
        waitClk(4);
        arstn = 1'b1;
        waitClk(10);
        expRxQ.push_back(8'h00);
        applyStimulus(8'h05, 1'b0, 24'h0, 0, 1, 4'b0010, 1, 0, 32'h0);
        expRxQ.push_back(8'hC8); expRxQ.push_back(8'h40);
        applyStimulus(8'h9F, 1'b0, 24'h0, 0, 1, 4'b0010, 2, 0, 32'h0);
        drainCheck();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
